// File: rtl/xadc_drp_responder.sv
// DRP-compatible stand-in for the XADC primitive: register file behind a DRP port plus a
// free-running temp/VCCINT/VCCAUX conversion sequencer fed by injected 12-bit codes.
module xadc_drp_responder #(
    parameter int CONV_CYCLES = 26,
    parameter int SEQ_GAP     = 4,
    parameter int DRP_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [6:0]  daddr_i,
    input  logic        den_i,
    input  logic        dwe_i,
    input  logic [15:0] di_i,
    output logic [15:0] do_o,
    output logic        drdy_o,
    output logic        busy_o,
    output logic        eos_o,
    output logic        proto_err_o,
    input  logic [11:0] temp_code_i,
    input  logic [11:0] vccint_code_i,
    input  logic [11:0] vccaux_code_i
);

    localparam logic [7:0] CONV_LAST = 8'(CONV_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(SEQ_GAP - 1);
    localparam logic [3:0] LAT_INIT  = 4'(DRP_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_TEMP,
        S_CONV_VCCINT,
        S_CONV_VCCAUX,
        S_GAP
    } seq_state_e;

    seq_state_e  state_q;
    logic [7:0]  seq_cnt_q;
    logic [15:0] temp_q, vccint_q, vccaux_q, maxtemp_q, mintemp_q;
    logic [15:0] cfg0_q, cfg1_q, cfg2_q;
    logic [15:0] rd_mux, rdata_q, temp_new;
    logic        pending_q, accept;
    logic [3:0]  lat_q;

    // DRP handshake: den_i is a one-cycle request, accepted only when nothing is pending or
    // on the very cycle the pending response completes. drdy_o is a one-cycle completion
    // strobe DRP_LATENCY cycles after the accepted den_i; do_o is zero outside that cycle.
    // A request arriving while one is pending is dropped and latches proto_err_o.
    assign drdy_o   = pending_q && (lat_q == 4'd0);
    assign do_o     = drdy_o ? rdata_q : 16'h0000;
    assign accept   = den_i && (!pending_q || drdy_o);
    assign temp_new = {temp_code_i, 4'h0};

    always_comb begin
        rd_mux = 16'h0000;
        case (daddr_i)
            7'h00:   rd_mux = temp_q;
            7'h01:   rd_mux = vccint_q;
            7'h02:   rd_mux = vccaux_q;
            7'h20:   rd_mux = maxtemp_q;
            7'h24:   rd_mux = mintemp_q;
            7'h40:   rd_mux = cfg0_q;
            7'h41:   rd_mux = cfg1_q;
            7'h42:   rd_mux = cfg2_q;
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q   <= 1'b0;
            lat_q       <= 4'd0;
            rdata_q     <= 16'h0000;
            proto_err_o <= 1'b0;
            cfg0_q      <= 16'h0000;
            cfg1_q      <= 16'h0000;
            cfg2_q      <= 16'h0400;
        end else if (accept) begin
            pending_q <= 1'b1;
            lat_q     <= LAT_INIT;
            rdata_q   <= rd_mux;
            if (dwe_i) begin
                case (daddr_i)
                    7'h40:   cfg0_q <= di_i;
                    7'h41:   cfg1_q <= di_i;
                    7'h42:   cfg2_q <= di_i;
                    default: ;
                endcase
            end
        end else begin
            if (den_i) proto_err_o <= 1'b1;
            if (pending_q) begin
                if (lat_q == 4'd0) pending_q <= 1'b0;
                else               lat_q     <= lat_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            seq_cnt_q <= 8'd0;
            busy_o    <= 1'b0;
            eos_o     <= 1'b0;
            temp_q    <= 16'h0000;
            vccint_q  <= 16'h0000;
            vccaux_q  <= 16'h0000;
            maxtemp_q <= 16'h0000;
            mintemp_q <= 16'hFFFF;
        end else begin
            eos_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!cfg1_q[15]) begin
                        state_q   <= S_CONV_TEMP;
                        seq_cnt_q <= 8'd0;
                        busy_o    <= 1'b1;
                    end
                end
                S_CONV_TEMP: begin
                    if (seq_cnt_q == CONV_LAST) begin
                        temp_q <= temp_new;
                        if (temp_new > maxtemp_q) maxtemp_q <= temp_new;
                        if (temp_new < mintemp_q) mintemp_q <= temp_new;
                        state_q   <= S_CONV_VCCINT;
                        seq_cnt_q <= 8'd0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 8'd1;
                    end
                end
                S_CONV_VCCINT: begin
                    if (seq_cnt_q == CONV_LAST) begin
                        vccint_q  <= {vccint_code_i, 4'h0};
                        state_q   <= S_CONV_VCCAUX;
                        seq_cnt_q <= 8'd0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 8'd1;
                    end
                end
                S_CONV_VCCAUX: begin
                    if (seq_cnt_q == CONV_LAST) begin
                        vccaux_q  <= {vccaux_code_i, 4'h0};
                        state_q   <= S_GAP;
                        seq_cnt_q <= 8'd0;
                        busy_o    <= 1'b0;
                        eos_o     <= 1'b1;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 8'd1;
                    end
                end
                S_GAP: begin
                    // Hold is only honoured here, so a hold written mid-sequence lets it finish.
                    if (seq_cnt_q == GAP_LAST) begin
                        seq_cnt_q <= 8'd0;
                        if (cfg1_q[15]) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_CONV_TEMP;
                            busy_o  <= 1'b1;
                        end
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
